battleship_engine: RTL and testbench

- Parametrised successor to the two-player battleship game controller.
- Owns both boards, the setup and turn state machine, shot resolution and win detection.
- Sits between the keypad decoder (key_value/key_valid) and the display/UART formatter (event stream, read port).
- Adds the following:
  - Configurable board dimensions and fleet size.
  - A cancel key.
  - Rejection of duplicate placements and duplicate shots.
  - An optional bonus-shot mode.
  - A registered board read port.
  - A winner flag.

---
 rtl/battleship_engine_if.sv | 39 +++
 rtl/battleship_engine.sv | 171 +++++++++++++++++
 tb/tb_battleship_engine.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/battleship_engine_if.sv
// Bus between the battleship engine and its keypad / display side.
// The master modport is the keypad decoder plus display formatter; the slave
// modport is the engine.
interface battleship_engine_if #(
   parameter int COORD_W = 3,
   parameter int CNT_W   = 4
);
   logic [3:0]         key_value;
   logic               key_valid;
   logic               rd_player;
   logic [COORD_W-1:0] rd_x;
   logic [COORD_W-1:0] rd_y;
   logic [1:0]         rd_cell;
   logic [2:0]         game_state;
   logic               coord_phase;
   logic [COORD_W-1:0] cursor_x;
   logic [COORD_W-1:0] cursor_y;
   logic [CNT_W-1:0]   ships_left_p1;
   logic [CNT_W-1:0]   ships_left_p2;
   logic [1:0]         winner;
   logic               evt_valid;
   logic [2:0]         evt_code;
   logic [COORD_W-1:0] evt_x;
   logic [COORD_W-1:0] evt_y;

   modport master (
      output key_value, key_valid, rd_player, rd_x, rd_y,
      input  rd_cell, game_state, coord_phase, cursor_x, cursor_y,
             ships_left_p1, ships_left_p2, winner,
             evt_valid, evt_code, evt_x, evt_y
   );

   modport slave (
      input  key_value, key_valid, rd_player, rd_x, rd_y,
      output rd_cell, game_state, coord_phase, cursor_x, cursor_y,
             ships_left_p1, ships_left_p2, winner,
             evt_valid, evt_code, evt_x, evt_y
   );
endinterface

// File: rtl/battleship_engine.sv
// Two-player battleship controller: both boards, setup/turn FSM, shot
// resolution, win detection, event stream and a registered board read port.
module battleship_engine #(
   parameter int BOARD_W    = 8,
   parameter int BOARD_H    = 8,
   parameter int COORD_W    = 3,
   parameter int SHIP_CELLS = 5,
   parameter int BONUS_SHOT = 0,
   parameter int CNT_W      = 4
) (
   input logic clk,
   input logic rst_n,
   battleship_engine_if.slave bus
);
   localparam int CELLS = BOARD_W * BOARD_H;
   localparam int AW    = $clog2(2 * CELLS);
   localparam logic [CNT_W-1:0] SHIPS      = CNT_W'(SHIP_CELLS);
   localparam logic [CNT_W-1:0] LAST_PLACE = CNT_W'(SHIP_CELLS - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_P1_SETUP = 3'd1, S_P2_SETUP = 3'd2,
      S_P1_TURN = 3'd3, S_P2_TURN = 3'd4, S_OVER = 3'd5
   } state_t;

   localparam logic [1:0] C_EMPTY = 2'b00, C_SHIP = 2'b01, C_HIT = 2'b10, C_MISS = 2'b11;
   localparam logic [2:0] E_START = 3'd0, E_PLACE = 3'd1, E_HIT = 3'd2, E_MISS = 3'd3,
                          E_REPEAT = 3'd4, E_BADKEY = 3'd5, E_CANCEL = 3'd6, E_RESTART = 3'd7;

   state_t             state_q, state_d;
   logic               phase_q, phase_d;
   logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
   logic [CNT_W-1:0]   placed_q, placed_d, left1_q, left1_d, left2_q, left2_d;
   logic [1:0]         winner_q, winner_d;
   logic               evt_valid_q, evt_valid_d;
   logic [2:0]         evt_code_q, evt_code_d;
   logic [COORD_W-1:0] evt_x_q, evt_x_d, evt_y_q, evt_y_d;
   logic [1:0]         rd_cell_q, rd_cell_d;

   logic [1:0]         board_w [2*CELLS];
   logic               wr_en, clr_all, tgt_player, rd_in_range, setup_phase;
   logic [1:0]         wr_val, cell_cur;
   logic [AW-1:0]      cidx, ridx;
   logic [COORD_W-1:0] key_coord;
   logic [CNT_W-1:0]   opp_left;
   state_t             pass_state;

   // P1 board occupies indices 0..CELLS-1, P2 board CELLS..2*CELLS-1.
   assign key_coord   = COORD_W'(bus.key_value);
   assign setup_phase = (state_q == S_P1_SETUP) || (state_q == S_P2_SETUP);
   assign tgt_player  = (state_q == S_P2_SETUP) || (state_q == S_P1_TURN);
   assign cidx        = AW'(tgt_player ? CELLS : 0) + AW'(int'(key_coord) * BOARD_W + int'(cur_x_q));
   assign cell_cur    = board_w[cidx];
   assign opp_left    = (state_q == S_P1_TURN) ? left2_q : left1_q;
   assign pass_state  = (state_q == S_P1_TURN) ? S_P2_TURN : S_P1_TURN;
   assign rd_in_range = (int'(bus.rd_x) < BOARD_W) && (int'(bus.rd_y) < BOARD_H);
   assign ridx        = AW'(bus.rd_player ? CELLS : 0) + AW'(int'(bus.rd_y) * BOARD_W + int'(bus.rd_x));
   assign rd_cell_d   = rd_in_range ? board_w[ridx] : C_EMPTY;

   // Cell storage; every cell clears on reset or restart, else takes the resolved write.
   for (genvar gi = 0; gi < 2 * CELLS; gi++) begin : g_cell
      logic [1:0] cell_q;
      always_ff @(posedge clk) begin
         if (!rst_n || clr_all)                  cell_q <= C_EMPTY;
         else if (wr_en && (cidx == AW'(gi)))    cell_q <= wr_val;
      end
      assign board_w[gi] = cell_q;
   end

   // Next-state logic: decode one key per cycle into state, counters, board write and event.
   always_comb begin
      state_d = state_q;   phase_d = phase_q;   cur_x_d = cur_x_q;   cur_y_d = cur_y_q;
      placed_d = placed_q; left1_d = left1_q;   left2_d = left2_q;   winner_d = winner_q;
      evt_valid_d = 1'b0;  evt_code_d = evt_code_q;
      evt_x_d = evt_x_q;   evt_y_d = evt_y_q;
      wr_en = 1'b0;        wr_val = C_EMPTY;    clr_all = 1'b0;
      if (bus.key_valid) begin
         // Non-commit events report the cursor; commits overwrite these below.
         evt_x_d = cur_x_q;
         evt_y_d = cur_y_q;
         case (state_q)
            S_IDLE: begin
               state_d = S_P1_SETUP; evt_valid_d = 1'b1; evt_code_d = E_START;
            end
            S_OVER: begin
               clr_all = 1'b1; left1_d = SHIPS; left2_d = SHIPS; placed_d = '0;
               winner_d = 2'b00; state_d = S_IDLE; evt_valid_d = 1'b1; evt_code_d = E_RESTART;
            end
            default: begin
               if (bus.key_value == 4'hF) begin
                  if (phase_q) begin
                     phase_d = 1'b0; evt_valid_d = 1'b1; evt_code_d = E_CANCEL;
                  end
               end else if (!phase_q) begin
                  if (int'(bus.key_value) < BOARD_W) begin
                     cur_x_d = key_coord; phase_d = 1'b1;
                  end else begin
                     evt_valid_d = 1'b1; evt_code_d = E_BADKEY;
                  end
               end else if (int'(bus.key_value) >= BOARD_H) begin
                  evt_valid_d = 1'b1; evt_code_d = E_BADKEY;
               end else begin
                  cur_y_d = key_coord; phase_d = 1'b0; evt_valid_d = 1'b1;
                  evt_x_d = cur_x_q;   evt_y_d = key_coord;
                  if (setup_phase) begin
                     if (cell_cur == C_EMPTY) begin
                        wr_en = 1'b1; wr_val = C_SHIP; evt_code_d = E_PLACE;
                        if (placed_q == LAST_PLACE) begin
                           placed_d = '0;
                           state_d  = (state_q == S_P1_SETUP) ? S_P2_SETUP : S_P1_TURN;
                        end else begin
                           placed_d = placed_q + CNT_W'(1);
                        end
                     end else begin
                        evt_code_d = E_REPEAT;
                     end
                  end else begin
                     case (cell_cur)
                        C_SHIP: begin
                           wr_en = 1'b1; wr_val = C_HIT; evt_code_d = E_HIT;
                           if (state_q == S_P1_TURN) begin
                              if (left2_q != '0) left2_d = left2_q - CNT_W'(1);
                           end else begin
                              if (left1_q != '0) left1_d = left1_q - CNT_W'(1);
                           end
                           if (opp_left == CNT_W'(1)) begin
                              state_d  = S_OVER;
                              winner_d = (state_q == S_P1_TURN) ? 2'b01 : 2'b10;
                           end else if (BONUS_SHOT == 0) begin
                              state_d = pass_state;
                           end
                        end
                        C_EMPTY: begin
                           wr_en = 1'b1; wr_val = C_MISS; evt_code_d = E_MISS; state_d = pass_state;
                        end
                        default: evt_code_d = E_REPEAT;
                     endcase
                  end
               end
            end
         endcase
      end
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE; phase_q <= 1'b0; cur_x_q <= '0; cur_y_q <= '0;
         placed_q <= '0; left1_q <= SHIPS; left2_q <= SHIPS; winner_q <= 2'b00;
         evt_valid_q <= 1'b0; evt_code_q <= 3'd0; evt_x_q <= '0; evt_y_q <= '0;
         rd_cell_q <= C_EMPTY;
      end else begin
         state_q <= state_d; phase_q <= phase_d; cur_x_q <= cur_x_d; cur_y_q <= cur_y_d;
         placed_q <= placed_d; left1_q <= left1_d; left2_q <= left2_d; winner_q <= winner_d;
         evt_valid_q <= evt_valid_d; evt_code_q <= evt_code_d; evt_x_q <= evt_x_d; evt_y_q <= evt_y_d;
         rd_cell_q <= rd_cell_d;
      end
   end

   assign bus.rd_cell       = rd_cell_q;
   assign bus.game_state    = state_q;
   assign bus.coord_phase   = phase_q;
   assign bus.cursor_x      = cur_x_q;
   assign bus.cursor_y      = cur_y_q;
   assign bus.ships_left_p1 = left1_q;
   assign bus.ships_left_p2 = left2_q;
   assign bus.winner        = winner_q;
   assign bus.evt_valid     = evt_valid_q;
   assign bus.evt_code      = evt_code_q;
   assign bus.evt_x         = evt_x_q;
   assign bus.evt_y         = evt_y_q;
endmodule

// File: tb/tb_battleship_engine.sv
// Directed bench: instance a uses default parameters, instance b uses a
// 6-wide board with bonus shots.
module tb_battleship_engine;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   battleship_engine_if #(.COORD_W(3), .CNT_W(4)) a_if ();
   battleship_engine_if #(.COORD_W(3), .CNT_W(4)) b_if ();

   battleship_engine dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
   battleship_engine #(.BOARD_W(6), .BONUS_SHOT(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

   task automatic press_a(input int k);
      @(negedge clk); a_if.key_value = 4'(k); a_if.key_valid = 1'b1;
      @(negedge clk); a_if.key_valid = 1'b0;
   endtask

   task automatic press_b(input int k);
      @(negedge clk); b_if.key_value = 4'(k); b_if.key_valid = 1'b1;
      @(negedge clk); b_if.key_valid = 1'b0;
   endtask

   task automatic read_a(input int p, input int x, input int y);
      @(negedge clk); a_if.rd_player = p[0]; a_if.rd_x = 3'(x); a_if.rd_y = 3'(y);
      @(negedge clk);
   endtask

   task automatic read_b(input int p, input int x, input int y);
      @(negedge clk); b_if.rd_player = p[0]; b_if.rd_x = 3'(x); b_if.rd_y = 3'(y);
      @(negedge clk);
   endtask

   // Place P1 at (1,1)..(5,1) and P2 at (0,0)..(4,0) on instance a from IDLE.
   task automatic fleet_a;
      press_a(0);
      for (int i = 1; i <= 5; i++) begin press_a(i); press_a(1); end
      for (int i = 0; i <= 4; i++) begin press_a(i); press_a(0); end
      checks++; if (a_if.game_state !== 3'd3) begin errors++; $display("FAIL fleet_a_state got %0d exp 3", a_if.game_state); end
   endtask

   task automatic test_reset;
      a_if.key_valid = 1'b0; a_if.key_value = 4'd0; a_if.rd_player = 1'b0; a_if.rd_x = 3'd0; a_if.rd_y = 3'd0;
      b_if.key_valid = 1'b0; b_if.key_value = 4'd0; b_if.rd_player = 1'b0; b_if.rd_x = 3'd0; b_if.rd_y = 3'd0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (a_if.game_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", a_if.game_state); end
      checks++; if (a_if.coord_phase !== 1'b0) begin errors++; $display("FAIL reset_phase got %0d exp 0", a_if.coord_phase); end
      checks++; if (a_if.ships_left_p1 !== 4'd5 || a_if.ships_left_p2 !== 4'd5) begin errors++; $display("FAIL reset_left got %0d/%0d exp 5/5", a_if.ships_left_p1, a_if.ships_left_p2); end
      checks++; if (a_if.winner !== 2'b00) begin errors++; $display("FAIL reset_winner got %0d exp 0", a_if.winner); end
      checks++; if (a_if.evt_valid !== 1'b0 || a_if.evt_code !== 3'd0) begin errors++; $display("FAIL reset_evt got v%0d c%0d exp v0 c0", a_if.evt_valid, a_if.evt_code); end
      checks++; if (a_if.rd_cell !== 2'b00) begin errors++; $display("FAIL reset_rd got %0d exp 0", a_if.rd_cell); end
   endtask

   task automatic test_setup;
      press_a(0);
      checks++; if (a_if.evt_valid !== 1'b1 || a_if.evt_code !== 3'd0 || a_if.game_state !== 3'd1) begin errors++; $display("FAIL start got v%0d c%0d s%0d exp v1 c0 s1", a_if.evt_valid, a_if.evt_code, a_if.game_state); end
      press_a(2);
      checks++; if (a_if.evt_valid !== 1'b0 || a_if.coord_phase !== 1'b1 || a_if.cursor_x !== 3'd2) begin errors++; $display("FAIL x_entry got v%0d ph%0d cx%0d exp v0 ph1 cx2", a_if.evt_valid, a_if.coord_phase, a_if.cursor_x); end
      press_a(2);
      checks++; if (a_if.evt_valid !== 1'b1 || a_if.evt_code !== 3'd1 || a_if.evt_x !== 3'd2 || a_if.evt_y !== 3'd2) begin errors++; $display("FAIL place22 got v%0d c%0d (%0d,%0d) exp v1 c1 (2,2)", a_if.evt_valid, a_if.evt_code, a_if.evt_x, a_if.evt_y); end
      press_a(2); press_a(2);
      checks++; if (a_if.evt_code !== 3'd4 || a_if.evt_x !== 3'd2 || a_if.evt_y !== 3'd2 || a_if.game_state !== 3'd1) begin errors++; $display("FAIL repeat22 got c%0d (%0d,%0d) s%0d exp c4 (2,2) s1", a_if.evt_code, a_if.evt_x, a_if.evt_y, a_if.game_state); end
      // Four more distinct cells; the fifth distinct placement ends P1 setup.
      for (int i = 0; i < 4; i++) begin
         int xs [4] = '{1, 3, 4, 5};
         int exp_s;
         exp_s = (i == 3) ? 2 : 1;
         press_a(xs[i]); press_a(1);
         checks++; if (a_if.evt_code !== 3'd1 || int'(a_if.evt_x) != xs[i] || int'(a_if.game_state) != exp_s) begin errors++; $display("FAIL p1_place%0d got c%0d x%0d s%0d exp c1 x%0d s%0d", i, a_if.evt_code, a_if.evt_x, a_if.game_state, xs[i], exp_s); end
      end
      for (int i = 0; i <= 4; i++) begin
         int exp_s;
         exp_s = (i == 4) ? 3 : 2;
         press_a(i); press_a(0);
         checks++; if (a_if.evt_code !== 3'd1 || int'(a_if.evt_x) != i || int'(a_if.game_state) != exp_s) begin errors++; $display("FAIL p2_place%0d got c%0d x%0d s%0d exp c1 x%0d s%0d", i, a_if.evt_code, a_if.evt_x, a_if.game_state, i, exp_s); end
      end
      read_a(0, 1, 1);
      checks++; if (a_if.rd_cell !== 2'b01) begin errors++; $display("FAIL rd_p1_11 got %0d exp 1", a_if.rd_cell); end
      read_a(0, 0, 0);
      checks++; if (a_if.rd_cell !== 2'b00) begin errors++; $display("FAIL rd_p1_00 got %0d exp 0", a_if.rd_cell); end
      read_a(1, 0, 0);
      checks++; if (a_if.rd_cell !== 2'b01) begin errors++; $display("FAIL rd_p2_00 got %0d exp 1", a_if.rd_cell); end
   endtask

   task automatic test_turns;
      press_a(0); press_a(0);
      checks++; if (a_if.evt_code !== 3'd2 || a_if.ships_left_p2 !== 4'd4 || a_if.game_state !== 3'd4) begin errors++; $display("FAIL p1_hit got c%0d left%0d s%0d exp c2 left4 s4", a_if.evt_code, a_if.ships_left_p2, a_if.game_state); end
      read_a(1, 0, 0);
      checks++; if (a_if.rd_cell !== 2'b10) begin errors++; $display("FAIL rd_hit got %0d exp 2", a_if.rd_cell); end
      press_a(7); press_a(7);
      checks++; if (a_if.evt_code !== 3'd3 || a_if.game_state !== 3'd3 || a_if.evt_x !== 3'd7 || a_if.evt_y !== 3'd7) begin errors++; $display("FAIL p2_miss got c%0d s%0d (%0d,%0d) exp c3 s3 (7,7)", a_if.evt_code, a_if.game_state, a_if.evt_x, a_if.evt_y); end
      read_a(0, 7, 7);
      checks++; if (a_if.rd_cell !== 2'b11) begin errors++; $display("FAIL rd_miss got %0d exp 3", a_if.rd_cell); end
      press_a(0); press_a(0);
      checks++; if (a_if.evt_code !== 3'd4 || a_if.game_state !== 3'd3 || a_if.ships_left_p2 !== 4'd4) begin errors++; $display("FAIL p1_repeat got c%0d s%0d left%0d exp c4 s3 left4", a_if.evt_code, a_if.game_state, a_if.ships_left_p2); end
   endtask

   task automatic test_win;
      for (int i = 1; i <= 4; i++) begin
         int exp_s;
         exp_s = (i == 4) ? 5 : 4;
         press_a(i); press_a(0);
         checks++; if (a_if.evt_code !== 3'd2 || int'(a_if.ships_left_p2) != 4 - i || int'(a_if.game_state) != exp_s) begin errors++; $display("FAIL win_hit%0d got c%0d left%0d s%0d exp c2 left%0d s%0d", i, a_if.evt_code, a_if.ships_left_p2, a_if.game_state, 4 - i, exp_s); end
         if (i < 4) begin press_a(7); press_a(7 - i); end
      end
      checks++; if (a_if.winner !== 2'b01 || a_if.ships_left_p1 !== 4'd5) begin errors++; $display("FAIL win_flag got w%0d p1left%0d exp w1 p1left5", a_if.winner, a_if.ships_left_p1); end
   endtask

   task automatic test_restart;
      press_a(9);
      checks++; if (a_if.evt_code !== 3'd7 || a_if.evt_valid !== 1'b1 || a_if.game_state !== 3'd0 || a_if.winner !== 2'b00) begin errors++; $display("FAIL restart got v%0d c%0d s%0d w%0d exp v1 c7 s0 w0", a_if.evt_valid, a_if.evt_code, a_if.game_state, a_if.winner); end
      checks++; if (a_if.evt_x !== 3'd4 || a_if.evt_y !== 3'd0 || a_if.ships_left_p1 !== 4'd5 || a_if.ships_left_p2 !== 4'd5) begin errors++; $display("FAIL restart_vals got (%0d,%0d) left%0d/%0d exp (4,0) left5/5", a_if.evt_x, a_if.evt_y, a_if.ships_left_p1, a_if.ships_left_p2); end
      read_a(1, 0, 0);
      checks++; if (a_if.rd_cell !== 2'b00) begin errors++; $display("FAIL restart_rd_p2 got %0d exp 0", a_if.rd_cell); end
      read_a(0, 7, 7);
      checks++; if (a_if.rd_cell !== 2'b00) begin errors++; $display("FAIL restart_rd_p1 got %0d exp 0", a_if.rd_cell); end
   endtask

   task automatic test_reset_mid;
      fleet_a();
      press_a(7); press_a(7);
      checks++; if (a_if.game_state !== 3'd4) begin errors++; $display("FAIL mid_state got %0d exp 4", a_if.game_state); end
      read_a(1, 1, 0);
      checks++; if (a_if.rd_cell !== 2'b01) begin errors++; $display("FAIL mid_rd got %0d exp 1", a_if.rd_cell); end
      // Reset collides with a key: reset must win, no event.
      @(negedge clk); a_if.key_value = 4'd3; a_if.key_valid = 1'b1; rst_n = 1'b0;
      @(negedge clk); a_if.key_valid = 1'b0;
      checks++; if (a_if.game_state !== 3'd0 || a_if.coord_phase !== 1'b0 || a_if.cursor_x !== 3'd0 || a_if.cursor_y !== 3'd0) begin errors++; $display("FAIL rstmid_ctl got s%0d ph%0d (%0d,%0d) exp s0 ph0 (0,0)", a_if.game_state, a_if.coord_phase, a_if.cursor_x, a_if.cursor_y); end
      checks++; if (a_if.evt_valid !== 1'b0 || a_if.evt_code !== 3'd0 || a_if.evt_x !== 3'd0 || a_if.evt_y !== 3'd0) begin errors++; $display("FAIL rstmid_evt got v%0d c%0d (%0d,%0d) exp v0 c0 (0,0)", a_if.evt_valid, a_if.evt_code, a_if.evt_x, a_if.evt_y); end
      checks++; if (a_if.rd_cell !== 2'b00 || a_if.winner !== 2'b00 || a_if.ships_left_p1 !== 4'd5 || a_if.ships_left_p2 !== 4'd5) begin errors++; $display("FAIL rstmid_out got rd%0d w%0d left%0d/%0d exp rd0 w0 left5/5", a_if.rd_cell, a_if.winner, a_if.ships_left_p1, a_if.ships_left_p2); end
      rst_n = 1'b1;
      read_a(1, 1, 0);
      checks++; if (a_if.rd_cell !== 2'b00) begin errors++; $display("FAIL rstmid_board got %0d exp 0", a_if.rd_cell); end
   endtask

   task automatic test_badkey_cancel;
      press_b(0);
      checks++; if (b_if.evt_code !== 3'd0 || b_if.game_state !== 3'd1) begin errors++; $display("FAIL b_start got c%0d s%0d exp c0 s1", b_if.evt_code, b_if.game_state); end
      press_b(7);
      checks++; if (b_if.evt_valid !== 1'b1 || b_if.evt_code !== 3'd5 || b_if.coord_phase !== 1'b0 || b_if.evt_x !== 3'd0) begin errors++; $display("FAIL badkey7 got v%0d c%0d ph%0d x%0d exp v1 c5 ph0 x0", b_if.evt_valid, b_if.evt_code, b_if.coord_phase, b_if.evt_x); end
      press_b(6);
      checks++; if (b_if.evt_code !== 3'd5 || b_if.coord_phase !== 1'b0) begin errors++; $display("FAIL badkey6 got c%0d ph%0d exp c5 ph0", b_if.evt_code, b_if.coord_phase); end
      press_b(5);
      checks++; if (b_if.evt_valid !== 1'b0 || b_if.coord_phase !== 1'b1 || b_if.cursor_x !== 3'd5) begin errors++; $display("FAIL x5 got v%0d ph%0d cx%0d exp v0 ph1 cx5", b_if.evt_valid, b_if.coord_phase, b_if.cursor_x); end
      press_b(8);
      checks++; if (b_if.evt_code !== 3'd5 || b_if.coord_phase !== 1'b1) begin errors++; $display("FAIL badkey_y8 got c%0d ph%0d exp c5 ph1", b_if.evt_code, b_if.coord_phase); end
      press_b(15);
      checks++; if (b_if.evt_valid !== 1'b1 || b_if.evt_code !== 3'd6 || b_if.coord_phase !== 1'b0 || b_if.evt_x !== 3'd5 || b_if.evt_y !== 3'd0) begin errors++; $display("FAIL cancel got v%0d c%0d ph%0d (%0d,%0d) exp v1 c6 ph0 (5,0)", b_if.evt_valid, b_if.evt_code, b_if.coord_phase, b_if.evt_x, b_if.evt_y); end
      press_b(15);
      checks++; if (b_if.evt_valid !== 1'b0 || b_if.coord_phase !== 1'b0) begin errors++; $display("FAIL cancel_ph0 got v%0d ph%0d exp v0 ph0", b_if.evt_valid, b_if.coord_phase); end
      for (int i = 0; i <= 4; i++) begin press_b(i); press_b(1); end
      for (int i = 0; i <= 4; i++) begin press_b(i); press_b(0); end
      checks++; if (b_if.game_state !== 3'd3) begin errors++; $display("FAIL b_fleet got s%0d exp s3", b_if.game_state); end
      read_b(0, 0, 1);
      checks++; if (b_if.rd_cell !== 2'b01) begin errors++; $display("FAIL b_rd_01 got %0d exp 1", b_if.rd_cell); end
      read_b(0, 6, 0);
      checks++; if (b_if.rd_cell !== 2'b00) begin errors++; $display("FAIL b_rd_oob got %0d exp 0", b_if.rd_cell); end
      read_b(0, 5, 0);
      checks++; if (b_if.rd_cell !== 2'b00) begin errors++; $display("FAIL b_rd_cancel got %0d exp 0", b_if.rd_cell); end
   endtask

   task automatic test_bonus;
      for (int i = 0; i <= 4; i++) begin
         int exp_s;
         exp_s = (i == 4) ? 5 : 3;
         press_b(i); press_b(0);
         checks++; if (b_if.evt_code !== 3'd2 || int'(b_if.ships_left_p2) != 4 - i || int'(b_if.game_state) != exp_s) begin errors++; $display("FAIL bonus_hit%0d got c%0d left%0d s%0d exp c2 left%0d s%0d", i, b_if.evt_code, b_if.ships_left_p2, b_if.game_state, 4 - i, exp_s); end
      end
      checks++; if (b_if.winner !== 2'b01) begin errors++; $display("FAIL bonus_winner got %0d exp 1", b_if.winner); end
   endtask

   initial begin
      test_reset();
      test_setup();
      test_turns();
      test_win();
      test_restart();
      test_reset_mid();
      test_badkey_cancel();
      test_bonus();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
